// File: rtl/xosera_bus_host.sv
// rtl/xosera_bus_host.sv - 68k-style bus initiator driving the Xosera register interface
// Optional strobe timeout: define XOSERA_BUS_TIMEOUT_EN.
module xosera_bus_host #(
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_byte_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_timeout_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_dtack_i
);

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic        dtk_meta, dtk;
  logic [3:0]  cnt, cnt_nxt;
  logic        is_byte, is_byte_nxt;
  logic [7:0]  lsb_wdata, lsb_wdata_nxt;
  logic [15:0] rdata_acc, rdata_acc_nxt;

  logic        ready_nxt, rsp_valid_nxt, cs_n_nxt, rd_nwr_nxt, bytesel_nxt, oe_nxt;
  logic [15:0] rsp_rdata_nxt;
  logic [3:0]  reg_num_nxt;
  logic [7:0]  data_nxt;

`ifdef XOSERA_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tcnt, tcnt_nxt;
  logic       timeout_q, timeout_nxt;
  assign rsp_timeout_o = timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // DTACK comes from another clock domain; only the synchronized copy is used.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      dtk_meta <= 1'b0;
      dtk      <= 1'b0;
    end else begin
      dtk_meta <= bus_dtack_i;
      dtk      <= dtk_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      is_byte       <= 1'b0;
      lsb_wdata     <= '0;
      rdata_acc     <= '0;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_bytesel_o <= 1'b0;
      bus_reg_num_o <= '0;
      bus_data_o    <= '0;
      bus_data_oe_o <= 1'b0;
`ifdef XOSERA_BUS_TIMEOUT_EN
      tcnt          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      is_byte       <= is_byte_nxt;
      lsb_wdata     <= lsb_wdata_nxt;
      rdata_acc     <= rdata_acc_nxt;
      req_ready_o   <= ready_nxt;
      rsp_valid_o   <= rsp_valid_nxt;
      rsp_rdata_o   <= rsp_rdata_nxt;
      bus_cs_n_o    <= cs_n_nxt;
      bus_rd_nwr_o  <= rd_nwr_nxt;
      bus_bytesel_o <= bytesel_nxt;
      bus_reg_num_o <= reg_num_nxt;
      bus_data_o    <= data_nxt;
      bus_data_oe_o <= oe_nxt;
`ifdef XOSERA_BUS_TIMEOUT_EN
      tcnt          <= tcnt_nxt;
      timeout_q     <= timeout_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    is_byte_nxt   = is_byte;
    lsb_wdata_nxt = lsb_wdata;
    rdata_acc_nxt = rdata_acc;
    ready_nxt     = req_ready_o;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata_o;
    cs_n_nxt      = bus_cs_n_o;
    rd_nwr_nxt    = bus_rd_nwr_o;
    bytesel_nxt   = bus_bytesel_o;
    reg_num_nxt   = bus_reg_num_o;
    data_nxt      = bus_data_o;
    oe_nxt        = bus_data_oe_o;
`ifdef XOSERA_BUS_TIMEOUT_EN
    tcnt_nxt      = tcnt;
    timeout_nxt   = timeout_q;
`endif

    case (state)
      S_IDLE: begin
        ready_nxt = 1'b1;
        cs_n_nxt  = 1'b1;
        if (req_valid_i && req_ready_o) begin
          ready_nxt     = 1'b0;
          is_byte_nxt   = req_byte_i;
          lsb_wdata_nxt = req_wdata_i[7:0];
          rdata_acc_nxt = '0;
          // a single-byte access only ever touches the odd byte
          bytesel_nxt   = req_byte_i;
          reg_num_nxt   = req_reg_num_i;
          rd_nwr_nxt    = !req_write_i;
          oe_nxt        = req_write_i;
          if (!req_write_i)
            data_nxt = 8'h00;
          else if (req_byte_i)
            data_nxt = req_wdata_i[7:0];
          else
            data_nxt = req_wdata_i[15:8];
          cnt_nxt       = SETUP_LD;
          state_nxt     = S_SETUP;
        end
      end

      S_SETUP: begin
        cs_n_nxt = 1'b1;
        if (cnt <= 4'd1) begin
          cs_n_nxt  = 1'b0;
          state_nxt = S_STROBE;
`ifdef XOSERA_BUS_TIMEOUT_EN
          tcnt_nxt  = '0;
`endif
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      S_STROBE: begin
`ifdef XOSERA_BUS_TIMEOUT_EN
        tcnt_nxt = tcnt + 8'd1;
`endif
        if (dtk) begin
          if (bus_rd_nwr_o) begin
            if (bus_bytesel_o)
              rdata_acc_nxt[7:0] = bus_data_i;
            else
              rdata_acc_nxt[15:8] = bus_data_i;
          end
          cs_n_nxt  = 1'b1;
          oe_nxt    = 1'b0;
          state_nxt = S_RELEASE;
        end
`ifdef XOSERA_BUS_TIMEOUT_EN
        else if (tcnt == TMO_LAST) begin
          // abandon the transfer, including any odd byte still pending
          cs_n_nxt      = 1'b1;
          oe_nxt        = 1'b0;
          ready_nxt     = 1'b1;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = rdata_acc;
          timeout_nxt   = 1'b1;
          state_nxt     = S_IDLE;
        end
`endif
      end

      S_RELEASE: begin
        cs_n_nxt = 1'b1;
        if (!dtk) begin
          cnt_nxt   = HOLD_LD;
          state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        cs_n_nxt = 1'b1;
        if (cnt <= 4'd1) begin
          if (!bus_bytesel_o && !is_byte) begin
            bytesel_nxt = 1'b1;
            data_nxt    = bus_rd_nwr_o ? 8'h00 : lsb_wdata;
            oe_nxt      = !bus_rd_nwr_o;
            cnt_nxt     = SETUP_LD;
            state_nxt   = S_SETUP;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = rdata_acc;
`ifdef XOSERA_BUS_TIMEOUT_EN
            timeout_nxt   = 1'b0;
`endif
            state_nxt     = S_DONE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      S_DONE: begin
        ready_nxt = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xosera_bus_host.sv
// tb/tb_xosera_bus_host.sv - scoreboard bench for xosera_bus_host with a DTACK responder model
module tb_xosera_bus_host;
  localparam int SETUP = 2;
  localparam int HOLD  = 1;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready_o;
  logic        req_write = 1'b0, req_byte = 1'b0;
  logic [3:0]  req_reg_num = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid_o, rsp_timeout_o;
  logic [15:0] rsp_rdata_o;
  logic        bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_data_oe_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data = 8'h00;
  logic        bus_dtack = 1'b0;

  always #5 clk = ~clk;

  xosera_bus_host #(.SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
    .req_byte_i(req_byte), .req_reg_num_i(req_reg_num), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
    .bus_cs_n_o(bus_cs_n_o), .bus_rd_nwr_o(bus_rd_nwr_o), .bus_bytesel_o(bus_bytesel_o),
    .bus_reg_num_o(bus_reg_num_o), .bus_data_o(bus_data_o), .bus_data_oe_o(bus_data_oe_o),
    .bus_data_i(bus_data), .bus_dtack_i(bus_dtack)
  );

  typedef struct packed {logic bytesel; logic rd_nwr; logic [3:0] reg_num; logic [7:0] data; logic oe;} strobe_t;
  typedef struct packed {logic [15:0] rdata; logic timeout;} rsp_t;
  typedef struct packed {logic wr; logic byt; logic [3:0] rn; logic [15:0] wd;} req_t;

  strobe_t exp_strobe[$], obs_strobe[$];
  rsp_t    exp_rsp[$], obs_rsp[$];
  int      obs_len[$], obs_gap[$];
  int      checks = 0, failures = 0, oe_viol = 0;

  // Responder: raise DTACK ack_delay cycles into the strobe, drop it once cs_n returns high.
  int         ack_delay = 3, low_cnt = 0;
  bit         never_ack = 1'b0;
  logic [7:0] even_byte = 8'h00, odd_byte = 8'h00;
  always @(negedge clk) begin
    if (bus_cs_n_o == 1'b0) begin
      low_cnt = low_cnt + 1;
      if (!never_ack && low_cnt >= ack_delay) begin
        bus_dtack = 1'b1;
        bus_data  = bus_bytesel_o ? odd_byte : even_byte;
      end
    end else begin
      low_cnt   = 0;
      bus_dtack = 1'b0;
      bus_data  = 8'h00;
    end
  end

  logic    prev_cs_n = 1'b1;
  int      cur_len = 0, cur_gap = 1000;
  strobe_t mon_s;
  rsp_t    mon_r;
  always @(negedge clk) begin
    if (bus_data_oe_o && bus_rd_nwr_o) oe_viol = oe_viol + 1;
    if (rsp_valid_o) begin
      mon_r = '{rsp_rdata_o, rsp_timeout_o};
      obs_rsp.push_back(mon_r);
    end
    if (prev_cs_n && !bus_cs_n_o) begin
      mon_s = '{bus_bytesel_o, bus_rd_nwr_o, bus_reg_num_o, bus_data_o, bus_data_oe_o};
      obs_strobe.push_back(mon_s);
      obs_gap.push_back(cur_gap);
      cur_len = 1;
    end else if (!bus_cs_n_o) begin
      cur_len = cur_len + 1;
    end else if (!prev_cs_n) begin
      obs_len.push_back(cur_len);
      cur_gap = 1;
    end else begin
      cur_gap = cur_gap + 1;
    end
    prev_cs_n = bus_cs_n_o;
  end

  task automatic clear_q();
    exp_strobe.delete(); obs_strobe.delete(); exp_rsp.delete(); obs_rsp.delete();
    obs_len.delete(); obs_gap.delete();
  endtask

  // Reference model: even byte first, odd byte second; uncaptured bytes read as zero.
  task automatic push_expect(input req_t r);
    strobe_t s;
    rsp_t    e;
    e = '{16'h0000, 1'b0};
    if (!r.byt) begin
      s = '{1'b0, !r.wr, r.rn, r.wr ? r.wd[15:8] : 8'h00, r.wr};
      exp_strobe.push_back(s);
      if (!r.wr) e.rdata[15:8] = even_byte;
    end
    s = '{1'b1, !r.wr, r.rn, r.wr ? r.wd[7:0] : 8'h00, r.wr};
    exp_strobe.push_back(s);
    if (!r.wr) e.rdata[7:0] = odd_byte;
    exp_rsp.push_back(e);
  endtask

  task automatic issue(input req_t r, output bit ok);
    req_write = r.wr; req_byte = r.byt; req_reg_num = r.rn; req_wdata = r.wd;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (req_ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 2000 && obs_rsp.size() < n; i++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    checks += 10;
    if (bus_cs_n_o !== 1'b1)      begin failures++; $display("FAIL rst_cs_n got=%b exp=1", bus_cs_n_o); end
    if (bus_rd_nwr_o !== 1'b1)    begin failures++; $display("FAIL rst_rd_nwr got=%b exp=1", bus_rd_nwr_o); end
    if (bus_bytesel_o !== 1'b0)   begin failures++; $display("FAIL rst_bytesel got=%b exp=0", bus_bytesel_o); end
    if (bus_reg_num_o !== 4'h0)   begin failures++; $display("FAIL rst_reg_num got=%h exp=0", bus_reg_num_o); end
    if (bus_data_o !== 8'h00)     begin failures++; $display("FAIL rst_data got=%h exp=00", bus_data_o); end
    if (bus_data_oe_o !== 1'b0)   begin failures++; $display("FAIL rst_oe got=%b exp=0", bus_data_oe_o); end
    if (rsp_valid_o !== 1'b0)     begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid_o); end
    if (rsp_rdata_o !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", rsp_rdata_o); end
    if (rsp_timeout_o !== 1'b0)   begin failures++; $display("FAIL rst_timeout got=%b exp=0", rsp_timeout_o); end
    if (req_ready_o !== 1'b1)     begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready_o); end
  endtask

  task automatic test_word_write();
    req_t r;
    bit ok;
    clear_q();
    r = '{1'b1, 1'b0, 4'd4, 16'hA55A};
    push_expect(r);
    issue(r, ok);
    wait_rsp(1);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL ww_accept got=0 exp=1"); end
    if (obs_strobe.size() != 2) begin failures++; $display("FAIL ww_strobe_count got=%0d exp=2", obs_strobe.size()); end
    if (obs_rsp.size() != 1) begin failures++; $display("FAIL ww_rsp_count got=%0d exp=1", obs_rsp.size()); end
    while (exp_strobe.size() > 0 && obs_strobe.size() > 0) begin
      strobe_t e, o;
      e = exp_strobe.pop_front(); o = obs_strobe.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL ww_strobe got=%h exp=%h", o, e); end
    end
    if (obs_rsp.size() > 0) begin
      checks++;
      if (obs_rsp[0] !== exp_rsp[0]) begin failures++; $display("FAIL ww_rsp got=%h exp=%h", obs_rsp[0], exp_rsp[0]); end
    end
  endtask

  task automatic test_word_read();
    req_t r;
    bit ok;
    clear_q();
    even_byte = 8'h12; odd_byte = 8'h34;
    r = '{1'b0, 1'b0, 4'd9, 16'h0000};
    push_expect(r);
    issue(r, ok);
    wait_rsp(1);
    checks += 3;
    if (obs_strobe.size() != 2) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=2", obs_strobe.size()); end
    if (obs_rsp.size() != 1) begin failures++; $display("FAIL wr_rsp_count got=%0d exp=1", obs_rsp.size()); end
    if (oe_viol != 0) begin failures++; $display("FAIL wr_oe_during_read got=%0d exp=0", oe_viol); end
    while (exp_strobe.size() > 0 && obs_strobe.size() > 0) begin
      strobe_t e, o;
      e = exp_strobe.pop_front(); o = obs_strobe.pop_front();
      e.data = 8'h00; o.data = 8'h00;
      checks++;
      if (o !== e) begin failures++; $display("FAIL wr_strobe got=%h exp=%h", o, e); end
    end
    if (obs_rsp.size() > 0) begin
      checks++;
      if (obs_rsp[0] !== exp_rsp[0]) begin failures++; $display("FAIL wr_rsp got=%h exp=%h", obs_rsp[0], exp_rsp[0]); end
    end
  endtask

  task automatic test_byte_read();
    req_t r;
    bit ok;
    clear_q();
    even_byte = 8'hEE; odd_byte = 8'h7E;
    r = '{1'b0, 1'b1, 4'd2, 16'h0000};
    push_expect(r);
    issue(r, ok);
    wait_rsp(1);
    checks += 2;
    if (obs_strobe.size() != 1) begin failures++; $display("FAIL br_strobe_count got=%0d exp=1", obs_strobe.size()); end
    if (obs_rsp.size() != 1) begin failures++; $display("FAIL br_rsp_count got=%0d exp=1", obs_rsp.size()); end
    if (obs_strobe.size() > 0) begin
      checks++;
      if (obs_strobe[0].bytesel !== 1'b1) begin failures++; $display("FAIL br_bytesel got=%b exp=1", obs_strobe[0].bytesel); end
    end
    if (obs_rsp.size() > 0) begin
      checks++;
      if (obs_rsp[0] !== exp_rsp[0]) begin failures++; $display("FAIL br_rsp got=%h exp=%h", obs_rsp[0], exp_rsp[0]); end
    end
  endtask

  task automatic test_back_to_back();
    req_t reqs[3];
    int   k = 0, rsp_seen = 0, busy_ready = 0;
    bit   pend = 1'b0, busy = 1'b0, prev_rsp = 1'b0;
    clear_q();
    even_byte = 8'h9C; odd_byte = 8'h3D;
    reqs[0] = '{1'b1, 1'b0, 4'd1, 16'h1357};
    reqs[1] = '{1'b1, 1'b1, 4'd3, 16'h00C4};
    reqs[2] = '{1'b0, 1'b0, 4'd5, 16'h0000};
    for (int i = 0; i < 3; i++) push_expect(reqs[i]);
    req_write = reqs[0].wr; req_byte = reqs[0].byt; req_reg_num = reqs[0].rn; req_wdata = reqs[0].wd;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 3000 && rsp_seen < 3; cyc++) begin
      if (req_valid && req_ready_o) pend = 1'b1;
      @(negedge clk);
      if (pend) begin
        pend = 1'b0; busy = 1'b1; k++;
        if (k < 3) begin
          req_write = reqs[k].wr; req_byte = reqs[k].byt; req_reg_num = reqs[k].rn; req_wdata = reqs[k].wd;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (prev_rsp) begin
        checks++;
        if (req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_rsp got=%b exp=1", req_ready_o); end
      end
      if (busy && req_ready_o) busy_ready++;
      if (rsp_valid_o) begin rsp_seen++; busy = 1'b0; end
      prev_rsp = rsp_valid_o;
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks += 3;
    if (busy_ready != 0) begin failures++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", busy_ready); end
    if (obs_rsp.size() != 3) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=3", obs_rsp.size()); end
    if (obs_strobe.size() != 5) begin failures++; $display("FAIL b2b_strobe_count got=%0d exp=5", obs_strobe.size()); end
    foreach (obs_gap[i]) begin
      checks++;
      if (obs_gap[i] < HOLD + SETUP) begin failures++; $display("FAIL b2b_gap got=%0d exp>=%0d", obs_gap[i], HOLD + SETUP); end
    end
    while (exp_strobe.size() > 0 && obs_strobe.size() > 0) begin
      strobe_t e, o;
      e = exp_strobe.pop_front(); o = obs_strobe.pop_front();
      if (!e.oe) begin e.data = 8'h00; o.data = 8'h00; end
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_strobe got=%h exp=%h", o, e); end
    end
    while (exp_rsp.size() > 0 && obs_rsp.size() > 0) begin
      rsp_t e, o;
      e = exp_rsp.pop_front(); o = obs_rsp.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_rsp got=%h exp=%h", o, e); end
    end
  endtask

`ifdef XOSERA_BUS_TIMEOUT_EN
  task automatic test_timeout();
    req_t r;
    rsp_t e;
    bit ok;
    clear_q();
    never_ack = 1'b1;
    r = '{1'b0, 1'b0, 4'd6, 16'h0000};
    e = '{16'h0000, 1'b1};
    issue(r, ok);
    wait_rsp(1);
    repeat (20) @(negedge clk);
    never_ack = 1'b0;
    checks += 2;
    if (obs_strobe.size() != 1) begin failures++; $display("FAIL to_strobe_count got=%0d exp=1", obs_strobe.size()); end
    if (obs_rsp.size() != 1) begin failures++; $display("FAIL to_rsp_count got=%0d exp=1", obs_rsp.size()); end
    if (obs_len.size() > 0) begin
      checks++;
      if (obs_len[0] != TMO) begin failures++; $display("FAIL to_cs_low_len got=%0d exp=%0d", obs_len[0], TMO); end
    end
    if (obs_rsp.size() > 0) begin
      checks++;
      if (obs_rsp[0] !== e) begin failures++; $display("FAIL to_rsp got=%h exp=%h", obs_rsp[0], e); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    req_t r;
    bit ok;
    clear_q();
    r = '{1'b1, 1'b0, 4'd7, 16'hBEEF};
    issue(r, ok);
    for (int i = 0; i < 100 && bus_cs_n_o; i++) @(negedge clk);
    checks++;
    if (bus_cs_n_o !== 1'b0) begin failures++; $display("FAIL rm_strobe_start got=%b exp=0", bus_cs_n_o); end
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus_cs_n_o !== 1'b1)    begin failures++; $display("FAIL rm_cs_n got=%b exp=1", bus_cs_n_o); end
    if (bus_data_oe_o !== 1'b0) begin failures++; $display("FAIL rm_oe got=%b exp=0", bus_data_oe_o); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_rsp.size() != 0) begin failures++; $display("FAIL rm_no_rsp got=%0d exp=0", obs_rsp.size()); end
    clear_q();
    even_byte = 8'h5C; odd_byte = 8'hA3;
    r = '{1'b0, 1'b0, 4'd8, 16'h0000};
    push_expect(r);
    issue(r, ok);
    wait_rsp(1);
    checks += 2;
    if (obs_strobe.size() != 2) begin failures++; $display("FAIL rm_next_strobes got=%0d exp=2", obs_strobe.size()); end
    if (obs_rsp.size() != 1) begin failures++; $display("FAIL rm_next_rsp_count got=%0d exp=1", obs_rsp.size()); end
    if (obs_rsp.size() > 0) begin
      checks++;
      if (obs_rsp[0] !== exp_rsp[0]) begin failures++; $display("FAIL rm_next_rsp got=%h exp=%h", obs_rsp[0], exp_rsp[0]); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_word_write();
    test_word_read();
    test_byte_read();
    test_back_to_back();
`ifdef XOSERA_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    checks++;
    if (oe_viol != 0) begin failures++; $display("FAIL oe_with_read got=%0d exp=0", oe_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
